// File: rtl/trng_pkg.sv
// -----------------------------------------------------------------------------
// trng_pkg
// Shared types and sizing helpers for the TRNG sampling path.
//   trng_state_e    : controller state (idle, warm-up, collect, hold)
//   DEF_*           : default parameter values of the sampler controller
//   *_cnt_width()   : clog2-derived counter widths for a given parameter set
// -----------------------------------------------------------------------------
package trng_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_HOLD    = 2'd3
    } trng_state_e;

    localparam int DEF_DIV_W     = 8;
    localparam int DEF_WORD_W    = 8;
    localparam int DEF_WARMUP    = 64;
    localparam int DEF_STUCK_LIM = 32;

    // Width able to hold every value 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

    // Accepted-bit counter: counts 0..WORD_W.
    function automatic int bit_cnt_width(input int word_w);
        return cnt_width(word_w);
    endfunction

    // Equal-pair run counter: saturates at STUCK_LIM.
    function automatic int rep_cnt_width(input int stuck_lim);
        return cnt_width(stuck_lim);
    endfunction

    // Warm-up tick counter: counts 0..WARMUP.
    function automatic int warm_cnt_width(input int warmup);
        return cnt_width(warmup);
    endfunction

endpackage

// File: rtl/trng_sync.sv
// -----------------------------------------------------------------------------
// trng_sync
// Two-flop synchroniser bringing the free-running entropy bit into clk.
//   clk : system clock
//   rst : asynchronous active-high reset, both flops to 0
//   d   : asynchronous input bit
//   q   : synchronised bit (two clocks of latency)
// -----------------------------------------------------------------------------
module trng_sync
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_r;

    // Two-stage capture of the asynchronous bit; always clocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_r <= 2'b00;
        end else begin
            ff_r <= {ff_r[0], d};
        end
    end

    assign q = ff_r[1];

endmodule

// File: rtl/trng_sampler_ctrl.sv
// -----------------------------------------------------------------------------
// trng_sampler_ctrl
// Sequencer for the TRNG entropy path: gates the oscillator, samples the
// synchronised entropy bit every div+1 cycles, drops a warm-up interval,
// von Neumann debiases sample pairs, packs WORD_W bits per output word and
// flags a stuck source after STUCK_LIM consecutive equal pairs.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : run request (level)
//   div        : sample period minus one, used live
//   raw_bit    : asynchronous entropy bit
//   osc_en     : oscillator enable
//   rnd_data   : debiased word, first accepted bit in the MSB
//   rnd_valid  : word valid, held until rnd_ready
//   rnd_ready  : consumer accepts the word
//   busy       : controller not idle
//   stuck      : sticky health failure, cleared by en=0 while idle
// -----------------------------------------------------------------------------
module trng_sampler_ctrl
    import trng_pkg::*;
#(
    parameter int DIV_W     = DEF_DIV_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int WARMUP    = DEF_WARMUP,
    parameter int STUCK_LIM = DEF_STUCK_LIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic              raw_bit,
    output logic              osc_en,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              busy,
    output logic              stuck
);

    localparam int BCNT_W = bit_cnt_width(WORD_W);
    localparam int RCNT_W = rep_cnt_width(STUCK_LIM);
    localparam int WCNT_W = warm_cnt_width(WARMUP);

    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] RCNT_LIM  = RCNT_W'(STUCK_LIM);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WARMUP - 1);

    trng_state_e        state_r;
    logic [DIV_W-1:0]   cnt_r;
    logic [WCNT_W-1:0]  warm_cnt_r;
    logic [BCNT_W-1:0]  bit_cnt_r;
    logic [RCNT_W-1:0]  rep_cnt_r;
    logic               phase_r;
    logic               first_r;
    logic [WORD_W-1:0]  word_r;
    logic [WORD_W-1:0]  rnd_data_r;
    logic               rnd_valid_r;
    logic               osc_en_r;
    logic               busy_r;
    logic               stuck_r;

    logic               sync_s;
    logic               tick_s;
    logic [RCNT_W-1:0]  rep_next_s;
    logic [WORD_W-1:0]  shifted_s;

    trng_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_bit),
        .q   (sync_s)
    );

    // Sample strobe and saturating equal-pair count.
    always_comb begin
        tick_s     = 1'b0;
        rep_next_s = rep_cnt_r;
        if ((state_r == ST_WARMUP) || (state_r == ST_COLLECT)) begin
            tick_s = (cnt_r == div);
        end else begin
            tick_s = 1'b0;
        end
        if (rep_cnt_r == RCNT_LIM) begin
            rep_next_s = RCNT_LIM;
        end else begin
            rep_next_s = rep_cnt_r + RCNT_ONE;
        end
    end

    // Word with the pending first sample appended at the LSB.
    assign shifted_s = {word_r[WORD_W-2:0], first_r};

    // Sample-period divider; held at zero whenever no samples are wanted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if ((state_r == ST_WARMUP) || (state_r == ST_COLLECT)) begin
            cnt_r <= tick_s ? {DIV_W{1'b0}} : (cnt_r + DIV_ONE);
        end else begin
            cnt_r <= {DIV_W{1'b0}};
        end
    end

    // Controller FSM with debiasing packer and stuck-source check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            warm_cnt_r  <= {WCNT_W{1'b0}};
            bit_cnt_r   <= {BCNT_W{1'b0}};
            rep_cnt_r   <= {RCNT_W{1'b0}};
            phase_r     <= 1'b0;
            first_r     <= 1'b0;
            word_r      <= {WORD_W{1'b0}};
            rnd_data_r  <= {WORD_W{1'b0}};
            rnd_valid_r <= 1'b0;
            osc_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            stuck_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    warm_cnt_r <= {WCNT_W{1'b0}};
                    bit_cnt_r  <= {BCNT_W{1'b0}};
                    phase_r    <= 1'b0;
                    if (!en) begin
                        stuck_r <= 1'b0;
                    end else if (!stuck_r) begin
                        state_r  <= ST_WARMUP;
                        osc_en_r <= 1'b1;
                        busy_r   <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (!en) begin
                        state_r  <= ST_IDLE;
                        osc_en_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end else if (tick_s) begin
                        if (warm_cnt_r == WCNT_LAST) begin
                            state_r    <= ST_COLLECT;
                            warm_cnt_r <= {WCNT_W{1'b0}};
                            phase_r    <= 1'b0;
                            bit_cnt_r  <= {BCNT_W{1'b0}};
                            rep_cnt_r  <= {RCNT_W{1'b0}};
                        end else begin
                            warm_cnt_r <= warm_cnt_r + WCNT_ONE;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (!en) begin
                        // Abandon the partial word; the next enable warms up again.
                        state_r   <= ST_IDLE;
                        osc_en_r  <= 1'b0;
                        busy_r    <= 1'b0;
                        phase_r   <= 1'b0;
                        bit_cnt_r <= {BCNT_W{1'b0}};
                        word_r    <= {WORD_W{1'b0}};
                    end else if (tick_s) begin
                        if (!phase_r) begin
                            first_r <= sync_s;
                            phase_r <= 1'b1;
                        end else begin
                            phase_r <= 1'b0;
                            if (first_r != sync_s) begin
                                // 10 -> 1, 01 -> 0: the first sample is the output bit.
                                word_r    <= shifted_s;
                                bit_cnt_r <= bit_cnt_r + BCNT_ONE;
                                rep_cnt_r <= {RCNT_W{1'b0}};
                                if (bit_cnt_r == BCNT_LAST) begin
                                    rnd_data_r  <= shifted_s;
                                    rnd_valid_r <= 1'b1;
                                    state_r     <= ST_HOLD;
                                end
                            end else begin
                                rep_cnt_r <= rep_next_s;
                                if (rep_next_s == RCNT_LIM) begin
                                    stuck_r   <= 1'b1;
                                    state_r   <= ST_IDLE;
                                    osc_en_r  <= 1'b0;
                                    busy_r    <= 1'b0;
                                    bit_cnt_r <= {BCNT_W{1'b0}};
                                    word_r    <= {WORD_W{1'b0}};
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // The word is always delivered, even if en has dropped meanwhile.
                    if (rnd_valid_r && rnd_ready) begin
                        rnd_valid_r <= 1'b0;
                        bit_cnt_r   <= {BCNT_W{1'b0}};
                        phase_r     <= 1'b0;
                        word_r      <= {WORD_W{1'b0}};
                        if (en) begin
                            state_r <= ST_COLLECT;
                        end else begin
                            state_r  <= ST_IDLE;
                            osc_en_r <= 1'b0;
                            busy_r   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rnd_valid_r <= 1'b0;
                    osc_en_r    <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign osc_en    = osc_en_r;
    assign rnd_data  = rnd_data_r;
    assign rnd_valid = rnd_valid_r;
    assign busy      = busy_r;
    assign stuck     = stuck_r;

endmodule

// File: tb/tb_trng_sampler_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trng_sampler_ctrl
// Self-checking bench: a behavioural reference model (queues and plain
// integers) is compared with the DUT on every clock; table-driven word
// vectors and hand-written sequences cover the multi-cycle corner cases;
// a randomized phase exercises en/ready/div/raw_bit combinations.
// -----------------------------------------------------------------------------
module tb_trng_sampler_ctrl;

    localparam int DIV_W     = 8;
    localparam int WORD_W    = 8;
    localparam int WARMUP    = 4;
    localparam int STUCK_LIM = 32;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_COLL = 2;
    localparam int M_HOLD = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [DIV_W-1:0]  div;
    logic              raw_bit;
    logic              osc_en;
    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              rnd_ready;
    logic              busy;
    logic              stuck;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int              m_mode;
    int              m_cnt;
    int              m_ticks;
    int              m_rep;
    int              m_first;
    bit              m_h1;
    bit              m_h2;
    bit              m_bits[$];
    bit              m_valid;
    bit              m_stuck;
    logic [WORD_W-1:0] m_data;

    typedef struct {
        logic [31:0]       pairs;
        int                npairs;
        logic [WORD_W-1:0] exp_word;
        int                exp_lat;
    } vec_t;

    vec_t vecs[5];

    // Free-running system clock.
    always #5 clk = ~clk;

    trng_sampler_ctrl #(
        .DIV_W     (DIV_W),
        .WORD_W    (WORD_W),
        .WARMUP    (WARMUP),
        .STUCK_LIM (STUCK_LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .raw_bit   (raw_bit),
        .osc_en    (osc_en),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy),
        .stuck     (stuck)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode  = M_IDLE;
        m_cnt   = 0;
        m_ticks = 0;
        m_rep   = 0;
        m_first = -1;
        m_h1    = 1'b0;
        m_h2    = 1'b0;
        m_bits.delete();
        m_valid = 1'b0;
        m_stuck = 1'b0;
        m_data  = '0;
    endtask

    // One clock edge of the behavioural model, from the inputs seen before it.
    task automatic m_edge(input bit e, input int d, input bit r, input bit q);
        bit s;
        bit running;
        bit tick;
        s    = m_h2;
        m_h2 = m_h1;
        m_h1 = r;
        running = (m_mode == M_WARM) || (m_mode == M_COLL);
        tick    = running && (m_cnt == d);
        if (!running || tick) m_cnt = 0;
        else                  m_cnt = (m_cnt + 1) % (1 << DIV_W);
        case (m_mode)
            M_IDLE: begin
                if (!e) m_stuck = 1'b0;
                else if (!m_stuck) begin
                    m_mode  = M_WARM;
                    m_ticks = 0;
                end
            end
            M_WARM: begin
                if (!e) m_mode = M_IDLE;
                else if (tick) begin
                    m_ticks++;
                    if (m_ticks == WARMUP) begin
                        m_mode  = M_COLL;
                        m_first = -1;
                        m_bits.delete();
                        m_rep   = 0;
                    end
                end
            end
            M_COLL: begin
                if (!e) m_mode = M_IDLE;
                else if (tick) begin
                    if (m_first < 0) m_first = s;
                    else begin
                        if (m_first != int'(s)) begin
                            m_bits.push_back(m_first == 1);
                            m_rep = 0;
                            if (m_bits.size() == WORD_W) begin
                                m_data = '0;
                                foreach (m_bits[i]) m_data[WORD_W-1-i] = m_bits[i];
                                m_valid = 1'b1;
                                m_mode  = M_HOLD;
                            end
                        end else begin
                            m_rep++;
                            if (m_rep >= STUCK_LIM) begin
                                m_stuck = 1'b1;
                                m_mode  = M_IDLE;
                            end
                        end
                        m_first = -1;
                    end
                end
            end
            default: begin
                if (m_valid && q) begin
                    m_valid = 1'b0;
                    m_bits.delete();
                    m_first = -1;
                    m_mode  = e ? M_COLL : M_IDLE;
                end
            end
        endcase
    endtask

    // Advance one clock, step the model, then compare all outputs.
    task automatic cyc();
        bit e, r, q;
        int d;
        e = en; r = raw_bit; q = rnd_ready; d = int'(div);
        @(posedge clk);
        if (rst) m_reset();
        else     m_edge(e, d, r, q);
        #1;
        chk("busy",      busy,      (m_mode != M_IDLE));
        chk("osc_en",    osc_en,    (m_mode != M_IDLE));
        chk("rnd_valid", rnd_valid, m_valid);
        chk("rnd_data",  rnd_data,  m_data);
        chk("stuck",     stuck,     m_stuck);
    endtask

    // Enable from idle (div=3), warm up, feed the pair samples, check the word.
    task automatic run_entry(input vec_t v, input bit drop_en_in_hold);
        int lat;
        int n;
        lat = -1;
        n   = 0;
        en  = 1'b1;
        cyc();
        for (int j = 0; j < WARMUP; j++) begin
            raw_bit = 1'($urandom);
            repeat (4) cyc();
        end
        for (int k = 0; k < 2 * v.npairs; k++) begin
            raw_bit = v.pairs[2 * v.npairs - 1 - k];
            for (int c = 0; c < 4; c++) begin
                cyc();
                n++;
                if (rnd_valid && lat < 0) lat = n;
            end
        end
        chk("word_latency", lat, v.exp_lat);
        chk("word_data", rnd_data, v.exp_word);
        if (drop_en_in_hold) en = 1'b0;
        repeat (20) cyc();
        chk("hold_valid", rnd_valid, 1'b1);
        chk("hold_data", rnd_data, v.exp_word);
        rnd_ready = 1'b1;
        cyc();
        rnd_ready = 1'b0;
        chk("after_hs_valid", rnd_valid, 1'b0);
        chk("after_hs_busy", busy, !drop_en_in_hold);
        en = 1'b0;
        cyc();
        cyc();
        chk("back_idle", busy, 1'b0);
    endtask

    initial begin
        int at;
        vecs[0] = '{32'h0000_9A59,  8, 8'hB2, 64};  // 10,01,10,10,01,01,10,01
        vecs[1] = '{32'h0008_7A59, 10, 8'hB2, 80};  // 00 and 11 inserted
        vecs[2] = '{32'h0000_AAAA,  8, 8'hFF, 64};  // all 10
        vecs[3] = '{32'h0000_5555,  8, 8'h00, 64};  // all 01
        vecs[4] = '{32'h0033_9999, 11, 8'hAA, 88};  // 11,00,11 then 10,01 x4

        rst = 1'b1; en = 1'b0; div = 8'd3; raw_bit = 1'b0; rnd_ready = 1'b0;
        m_reset();
        repeat (3) cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", rnd_valid, 1'b0);
        rst = 1'b0;
        cyc();

        // Word vectors, including discarded equal pairs.
        foreach (vecs[i]) run_entry(vecs[i], 1'b0);

        // en dropped after three accepted bits: partial word is thrown away.
        en = 1'b1;
        cyc();
        for (int j = 0; j < WARMUP + 6; j++) begin
            if (j < WARMUP) raw_bit = 1'($urandom);
            else            raw_bit = (j == 4 || j == 7 || j == 8);  // 10,01,10
            repeat (4) cyc();
        end
        en = 1'b0;
        cyc();
        chk("drop_busy", busy, 1'b0);
        chk("drop_osc_en", osc_en, 1'b0);
        run_entry(vecs[0], 1'b0);

        // en dropped while holding: word delivered, then idle.
        run_entry(vecs[0], 1'b1);

        // Stuck source: raw held 1 with a tick every cycle.
        div = 8'd0; raw_bit = 1'b1;
        repeat (3) cyc();
        en = 1'b1;
        cyc();
        at = -1;
        for (int i = 1; i <= 200; i++) begin
            cyc();
            if (stuck && at < 0) begin
                at = i;
                break;
            end
        end
        chk("stuck_cycles", at, WARMUP + 2 * STUCK_LIM);
        chk("stuck_osc_en", osc_en, 1'b0);
        repeat (10) cyc();
        chk("stuck_no_restart", busy, 1'b0);
        en = 1'b0;
        cyc();
        chk("stuck_cleared", stuck, 1'b0);
        en = 1'b1;
        cyc();
        chk("restart_busy", busy, 1'b1);
        en = 1'b0;
        repeat (2) cyc();

        // Randomized traffic against the model.
        begin
            int off;
            off = 0;
            en  = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if (i % 500 == 0) div = 8'($urandom_range(0, 2));
                if ((i % 700) >= 350 && (i % 700) < 500) raw_bit = 1'b1;
                else                                     raw_bit = 1'($urandom);
                rnd_ready = ($urandom_range(0, 3) == 0);
                if (off > 0) off--;
                else if ($urandom_range(0, 199) == 0) off = $urandom_range(1, 5);
                en = (off == 0);
                cyc();
            end
        end

        // Asynchronous reset while a word is held.
        en = 1'b0; rnd_ready = 1'b0; div = 8'd0;
        repeat (2) cyc();
        en = 1'b1;
        for (int i = 0; i < 500 && !rnd_valid; i++) begin
            raw_bit = 1'($urandom);
            cyc();
        end
        chk("pre_rst_valid", rnd_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_osc_en", osc_en, 1'b0);
        chk("arst_valid", rnd_valid, 1'b0);
        chk("arst_data", rnd_data, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_stuck", stuck, 1'b0);
        m_reset();
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_busy", busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
